// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
// Module : cal_pkg
// Brief  : Shared state codes (equal to the display field codes) and the
//          calendar constants used by the date sequencer.
// Rev    : 1.0
// ============================================================================
package cal_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_YEAR  = 2'd1,
    SET_MONTH = 2'd2,
    SET_DAY   = 2'd3
  } cal_state_e;

  localparam logic [3:0] FEB       = 4'd2;
  localparam logic [3:0] DEC       = 4'd12;
  localparam logic [4:0] DAY_MIN   = 5'd1;
  localparam logic [3:0] MONTH_MIN = 4'd1;

endpackage
`default_nettype wire

// File: rtl/days_in_month.sv
`default_nettype none
// ============================================================================
// Module : days_in_month
// Brief  : Combinational month length; February is 29 days in years 00, 04...
// Rev    : 1.0
// ============================================================================
module days_in_month
  import cal_pkg::*;
(
  input  logic [3:0] month_i,
  input  logic [5:0] year_i,
  output logic [4:0] dim_o
);

  // Only the low two year bits decide the leap rule in the 2000..2063 range.
  logic unused_year_hi;
  assign unused_year_hi = ^year_i[5:2];

  always_comb begin
    dim_o = 5'd31;
    case (month_i)
      4'd4, 4'd6, 4'd9, 4'd11: dim_o = 5'd30;
      FEB:                     dim_o = (year_i[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 dim_o = 5'd31;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/calendar_ctrl.sv
`default_nettype none
// ============================================================================
// Module : calendar_ctrl
// Brief  : Day/month/year sequencer with button-driven set mode and timeout.
// Rev    : 1.0
// ============================================================================
module calendar_ctrl
  import cal_pkg::*;
#(
  parameter int YEAR_MAX  = 59,
  parameter int TIMEOUT_S = 30,
  parameter int TO_W      = 5
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       day_tick,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [5:0] year,
  output logic       set_active,
  output logic [1:0] field_sel,
  output logic       year_wrap
);

  localparam logic [5:0]      YEAR_LAST = 6'(YEAR_MAX);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_S - 1);

  cal_state_e      state_q, state_d;
  logic [4:0]      day_q, day_d, day_pre;
  logic [3:0]      month_q, month_d;
  logic [5:0]      year_q, year_d;
  logic            pending_q, pending_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            set_active_q;
  logic            year_wrap_q, year_wrap_d;
  logic            clamp_en;
  logic [4:0]      dim_live, dim_next;

  days_in_month u_dim_live (
    .month_i (month_q),
    .year_i  (year_q),
    .dim_o   (dim_live)
  );

  // Clamp must see the month/year that will exist after this edge.
  days_in_month u_dim_next (
    .month_i (month_d),
    .year_i  (year_d),
    .dim_o   (dim_next)
  );

  always_comb begin
    state_d     = state_q;
    day_pre     = day_q;
    month_d     = month_q;
    year_d      = year_q;
    pending_d   = pending_q;
    to_d        = to_q;
    year_wrap_d = 1'b0;
    clamp_en    = 1'b0;

    case (state_q)
      RUN: begin
        pending_d = 1'b0;
        if (day_tick || pending_q) begin
          if (day_q < dim_live) begin
            day_pre = day_q + 5'd1;
          end else begin
            day_pre = DAY_MIN;
            if (month_q < DEC) begin
              month_d = month_q + 4'd1;
            end else begin
              month_d = MONTH_MIN;
              if (year_q == YEAR_LAST) begin
                year_d      = 6'd0;
                year_wrap_d = 1'b1;
              end else begin
                year_d = year_q + 6'd1;
              end
            end
          end
        end
        if (btn_mode) begin
          state_d = SET_YEAR;
          to_d    = '0;
        end
      end

      SET_YEAR, SET_MONTH, SET_DAY: begin
        if (day_tick) pending_d = 1'b1;
        if (btn_mode) begin
          to_d = '0;
          case (state_q)
            SET_YEAR:  state_d = SET_MONTH;
            SET_MONTH: state_d = SET_DAY;
            default:   state_d = RUN;
          endcase
        end else if (btn_up) begin
          to_d = '0;
          case (state_q)
            SET_YEAR:  year_d  = (year_q == YEAR_LAST) ? 6'd0 : year_q + 6'd1;
            SET_MONTH: month_d = (month_q >= DEC) ? MONTH_MIN : month_q + 4'd1;
            default:   day_pre = (day_q >= dim_live) ? DAY_MIN : day_q + 5'd1;
          endcase
        end else if (sec_tick) begin
          if (to_q == TO_LAST) begin
            to_d    = '0;
            state_d = RUN;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        clamp_en = (state_d != state_q);
      end

      default: state_d = RUN;
    endcase
  end

  always_comb begin
    day_d = day_pre;
    if (clamp_en && (day_pre > dim_next)) day_d = dim_next;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= RUN;
      day_q        <= DAY_MIN;
      month_q      <= MONTH_MIN;
      year_q       <= 6'd0;
      pending_q    <= 1'b0;
      to_q         <= '0;
      set_active_q <= 1'b0;
      year_wrap_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      pending_q    <= pending_d;
      to_q         <= to_d;
      set_active_q <= (state_d != RUN);
      year_wrap_q  <= year_wrap_d;
    end
  end

  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign set_active = set_active_q;
  assign field_sel  = state_q;
  assign year_wrap  = year_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_calendar_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_calendar_ctrl
// Brief  : Directed scenarios plus randomized run against a calendar model.
// Rev    : 1.0
// ============================================================================
module tb_calendar_ctrl;

  localparam int YEAR_MAX  = 59;
  localparam int TIMEOUT_S = 30;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       day_tick = 1'b0;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [4:0] day;
  logic [3:0] month;
  logic [5:0] year;
  logic       set_active;
  logic [1:0] field_sel;
  logic       year_wrap;

  calendar_ctrl #(
    .YEAR_MAX  (YEAR_MAX),
    .TIMEOUT_S (TIMEOUT_S),
    .TO_W      (5)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .day_tick   (day_tick),
    .sec_tick   (sec_tick),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .day        (day),
    .month      (month),
    .year       (year),
    .set_active (set_active),
    .field_sel  (field_sel),
    .year_wrap  (year_wrap)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  // Model: mode 0 = running, 1/2/3 = editing year/month/day.
  int m_day, m_month, m_year, m_mode, m_pend, m_to, m_wrap;

  function automatic int m_dim(input int mo, input int yr);
    int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && (yr % 4) == 0) return 29;
    return lens[mo-1];
  endfunction

  task automatic model_reset();
    m_day = 1; m_month = 1; m_year = 0; m_mode = 0; m_pend = 0; m_to = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit dt, input bit st, input bit bm, input bit bu);
    m_wrap = 0;
    if (m_mode == 0) begin
      if (dt || m_pend != 0) begin
        m_day++;
        if (m_day > m_dim(m_month, m_year)) begin
          m_day = 1;
          m_month++;
          if (m_month > 12) begin
            m_month = 1;
            m_year++;
            if (m_year > YEAR_MAX) begin
              m_year = 0;
              m_wrap = 1;
            end
          end
        end
      end
      m_pend = 0;
      if (bm) begin
        m_mode = 1;
        m_to   = 0;
      end
    end else begin
      int nxt = m_mode;
      if (dt) m_pend = 1;
      if (bm) begin
        m_to = 0;
        nxt  = (m_mode + 1) % 4;
      end else if (bu) begin
        m_to = 0;
        case (m_mode)
          1:       m_year  = (m_year + 1) % (YEAR_MAX + 1);
          2:       m_month = m_month % 12 + 1;
          default: m_day   = m_day % m_dim(m_month, m_year) + 1;
        endcase
      end else if (st) begin
        m_to++;
        if (m_to >= TIMEOUT_S) begin
          m_to = 0;
          nxt  = 0;
        end
      end
      if (nxt != m_mode) begin
        if (m_day > m_dim(m_month, m_year)) m_day = m_dim(m_month, m_year);
        m_mode = nxt;
      end
    end
  endtask

  // One clock: inputs held across the edge, outputs observable 1 time unit later.
  task automatic cycle(input bit dt, input bit st, input bit bm, input bit bu);
    day_tick = dt; sec_tick = st; btn_mode = bm; btn_up = bu;
    @(posedge clk);
    model_step(dt, st, bm, bu);
    #1;
    day_tick = 1'b0; sec_tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
  endtask

  task automatic set_date(input int d, input int mo, input int y);
    cycle(0, 0, 1, 0);
    repeat ((y - m_year + YEAR_MAX + 1) % (YEAR_MAX + 1)) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    repeat ((mo - m_month + 12) % 12) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    repeat ((d - m_day + m_dim(m_month, m_year)) % m_dim(m_month, m_year)) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_reset();
    tests_run++;
    if (day !== 5'd1 || month !== 4'd1 || year !== 6'd0 || field_sel !== 2'd0 ||
        set_active !== 1'b0 || year_wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: got %0d/%0d/%0d sel=%0d act=%b wrap=%b, want 1/1/0 sel=0 act=0 wrap=0",
               day, month, year, field_sel, set_active, year_wrap);
    end
    clear_n = 1'b1;
    cycle(0, 0, 0, 0);
    tests_run++;
    if (day !== 5'd1 || month !== 4'd1 || year !== 6'd0 || field_sel !== 2'd0) begin
      fails++;
      $display("FAIL reset_release: got %0d/%0d/%0d sel=%0d, want 1/1/0 sel=0",
               day, month, year, field_sel);
    end
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    tests_run++;
    if (field_sel !== 2'd2 || month !== 4'd2 || set_active !== 1'b1) begin
      fails++;
      $display("FAIL reset_setup_month: got sel=%0d month=%0d act=%b, want sel=2 month=2 act=1",
               field_sel, month, set_active);
    end
    #1 clear_n = 1'b0;
    #1;
    tests_run++;
    if (day !== 5'd1 || month !== 4'd1 || year !== 6'd0 || field_sel !== 2'd0 ||
        set_active !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: got %0d/%0d/%0d sel=%0d act=%b, want 1/1/0 sel=0 act=0",
               day, month, year, field_sel, set_active);
    end
    model_reset();
    clear_n = 1'b1;
  endtask

  task automatic test_year_wrap();
    set_date(31, 12, 59);
    tests_run++;
    if (day !== 5'd31 || month !== 4'd12 || year !== 6'd59 || field_sel !== 2'd0) begin
      fails++;
      $display("FAIL wrap_setup: got %0d/%0d/%0d sel=%0d, want 31/12/59 sel=0",
               day, month, year, field_sel);
    end
    cycle(1, 0, 0, 0);
    tests_run++;
    if (day !== 5'd1 || month !== 4'd1 || year !== 6'd0 || year_wrap !== 1'b1) begin
      fails++;
      $display("FAIL wrap_tick: got %0d/%0d/%0d wrap=%b, want 1/1/0 wrap=1",
               day, month, year, year_wrap);
    end
    cycle(0, 0, 0, 0);
    tests_run++;
    if (year_wrap !== 1'b0 || day !== 5'd1 || year !== 6'd0) begin
      fails++;
      $display("FAIL wrap_pulse_len: got wrap=%b day=%0d year=%0d, want wrap=0 day=1 year=0",
               year_wrap, day, year);
    end
  endtask

  task automatic test_leap();
    set_date(28, 2, 4);
    cycle(1, 0, 0, 0);
    tests_run++;
    if (day !== 5'd29 || month !== 4'd2) begin
      fails++;
      $display("FAIL leap_29: got %0d/%0d, want 29/2", day, month);
    end
    cycle(1, 0, 0, 0);
    tests_run++;
    if (day !== 5'd1 || month !== 4'd3) begin
      fails++;
      $display("FAIL leap_mar: got %0d/%0d, want 1/3", day, month);
    end
    set_date(28, 2, 5);
    cycle(1, 0, 0, 0);
    tests_run++;
    if (day !== 5'd1 || month !== 4'd3 || year !== 6'd5) begin
      fails++;
      $display("FAIL nonleap_mar: got %0d/%0d/%0d, want 1/3/5", day, month, year);
    end
  endtask

  task automatic test_clamp();
    set_date(31, 1, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    tests_run++;
    if (day !== 5'd31 || month !== 4'd2 || field_sel !== 2'd2) begin
      fails++;
      $display("FAIL clamp_before: got day=%0d month=%0d sel=%0d, want 31 2 sel=2",
               day, month, field_sel);
    end
    cycle(0, 0, 1, 0);
    tests_run++;
    if (day !== 5'd28 || field_sel !== 2'd3) begin
      fails++;
      $display("FAIL clamp_after: got day=%0d sel=%0d, want 28 sel=3", day, field_sel);
    end
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_pending();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    tests_run++;
    if (day !== 5'd28 || month !== 4'd2 || field_sel !== 2'd3) begin
      fails++;
      $display("FAIL pend_held: got %0d/%0d sel=%0d, want 28/2 sel=3", day, month, field_sel);
    end
    cycle(0, 0, 1, 0);
    tests_run++;
    if (day !== 5'd28 || field_sel !== 2'd0 || set_active !== 1'b0) begin
      fails++;
      $display("FAIL pend_exit: got day=%0d sel=%0d act=%b, want 28 sel=0 act=0",
               day, field_sel, set_active);
    end
    cycle(0, 0, 0, 0);
    tests_run++;
    if (day !== 5'd1 || month !== 4'd3) begin
      fails++;
      $display("FAIL pend_apply: got %0d/%0d, want 1/3", day, month);
    end
    cycle(0, 0, 0, 0);
    tests_run++;
    if (day !== 5'd1 || month !== 4'd3) begin
      fails++;
      $display("FAIL pend_once: got %0d/%0d, want 1/3", day, month);
    end
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    tests_run++;
    if (day !== 5'd2 || month !== 4'd3) begin
      fails++;
      $display("FAIL pend_coincide: got %0d/%0d, want 2/3", day, month);
    end
  endtask

  task automatic test_simul_buttons();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    tests_run++;
    if (field_sel !== 2'd2 || year !== 6'd1) begin
      fails++;
      $display("FAIL mode_wins: got sel=%0d year=%0d, want sel=2 year=1", field_sel, year);
    end
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_timeout();
    cycle(0, 0, 1, 0);
    repeat (29) begin
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
    end
    tests_run++;
    if (set_active !== 1'b1 || field_sel !== 2'd1) begin
      fails++;
      $display("FAIL timeout_29: got act=%b sel=%0d, want act=1 sel=1", set_active, field_sel);
    end
    cycle(0, 1, 0, 0);
    tests_run++;
    if (set_active !== 1'b0 || field_sel !== 2'd0) begin
      fails++;
      $display("FAIL timeout_30: got act=%b sel=%0d, want act=0 sel=0", set_active, field_sel);
    end
    cycle(0, 0, 1, 0);
    repeat (28) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    repeat (29) cycle(0, 1, 0, 0);
    tests_run++;
    if (set_active !== 1'b1 || year !== 6'd2) begin
      fails++;
      $display("FAIL timeout_restart: got act=%b year=%0d, want act=1 year=2", set_active, year);
    end
    cycle(0, 1, 0, 0);
    tests_run++;
    if (set_active !== 1'b0 || year !== 6'd2 || day !== 5'd2 || month !== 4'd3) begin
      fails++;
      $display("FAIL timeout_keep: got act=%b %0d/%0d/%0d, want act=0 2/3/2",
               set_active, day, month, year);
    end
  endtask

  task automatic test_random();
    bit dt, st, bm, bu, quiet;
    for (int i = 0; i < 6000; i++) begin
      quiet = ((i / 300) % 2) == 1;
      dt = ($urandom % 6) == 0;
      st = ($urandom % 3) == 0;
      bm = quiet ? (($urandom % 200) == 0) : (($urandom % 10) == 0);
      bu = quiet ? (($urandom % 150) == 0) : (($urandom % 3) == 0);
      cycle(dt, st, bm, bu);
      tests_run++;
      if (day !== 5'(m_day) || month !== 4'(m_month) || year !== 6'(m_year) ||
          field_sel !== 2'(m_mode) || set_active !== (m_mode != 0) ||
          year_wrap !== 1'(m_wrap)) begin
        fails++;
        if (fails < 20)
          $display("FAIL random[%0d]: got %0d/%0d/%0d sel=%0d act=%b wrap=%b, want %0d/%0d/%0d sel=%0d wrap=%0d",
                   i, day, month, year, field_sel, set_active, year_wrap,
                   m_day, m_month, m_year, m_mode, m_wrap);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_year_wrap();
    test_leap();
    test_clamp();
    test_pending();
    test_simul_buttons();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
